fpmul_norm_ctrl: RTL and testbench

Multi-cycle normalize/round/pack sequencer for the single-precision floating-point multiplier. It accepts the raw 48-bit mantissa product, the sign and the pre-adjusted exponent sum from the multiplier array. It then walks them through leading-one detection, left shift, round-to-nearest-even and a conditional renormalize, and presents an IEEE-754 binary32 word on a valid/ready output. It sits between the mantissa multiplier and the result register and owns all exponent adjustment and overflow/underflow decisions.

---
 rtl/fpmul_pkg.sv | 57 +++++
 rtl/fpmul_lzc48.sv | 23 ++
 rtl/fpmul_norm_ctrl.sv | 162 ++++++++++++++++
 tb/tb_fpmul_norm_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpmul_pkg.sv
// Shared types, constants and the binary32 pack helper for the FP multiplier
// normalize/round/pack sequencer.
//   state_t    : sequencer states
//   fp32_t     : binary32 field layout
//   pack_res_t : packed word plus overflow/underflow flags
package fpmul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NORM   = 3'd1,
    ST_ROUND  = 3'd2,
    ST_RENORM = 3'd3,
    ST_OUT    = 3'd4
  } state_t;

  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned EXP_MAX  = 255;
  localparam int unsigned FRAC_W   = 23;
  localparam int unsigned MANT_W   = 48;
  localparam int unsigned E_W      = 12;  // internal signed exponent width
  localparam int unsigned LZ_W     = 6;

  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef struct packed {
    fp32_t word;
    logic  ovf;
    logic  unf;
  } pack_res_t;

  // Final range check and field packing; zero beats overflow beats underflow.
  function automatic pack_res_t pack_fp32(input logic              sign,
                                          input logic              zero,
                                          input logic signed [E_W-1:0] e,
                                          input logic [FRAC_W-1:0] frac);
    pack_res_t r;
    r           = '0;
    r.word.sign = sign;
    if (!zero) begin
      if (e >= $signed(E_W'(EXP_MAX))) begin
        r.word.exp = 8'hFF;
        r.ovf      = 1'b1;
      end else if (e <= $signed(E_W'(0))) begin
        r.unf = 1'b1;
      end else begin
        r.word.exp  = e[7:0];
        r.word.frac = frac;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fpmul_lzc48.sv
// Combinational 48-bit leading-zero counter.
//   mant : value to scan
//   lz   : number of zeros above the leading one (0 when mant is zero)
//   zero : mant is all zeros
module fpmul_lzc48
  import fpmul_pkg::*;
(
  input  logic [MANT_W-1:0] mant,
  output logic [LZ_W-1:0]   lz,
  output logic              zero
);

  // Scan upward so the highest set bit wins.
  always_comb begin
    lz = '0;
    for (int i = 0; i < MANT_W; i++) begin
      if (mant[i]) lz = LZ_W'(MANT_W - 1 - i);
    end
  end

  assign zero = ~|mant;

endmodule

// File: rtl/fpmul_norm_ctrl.sv
// Normalize/round/pack sequencer for the single-precision multiplier.
// Takes the raw 48-bit significand product, sign and biased exponent sum and
// returns a binary32 word over a valid/ready handshake.
// Macro FPMUL_RNE_EN: when defined, adds ROUND/RENORM (round-to-nearest-even);
// otherwise the fraction is truncated and NORM goes straight to OUT.
//   clk, rst              : clock, async active-high reset
//   in_valid/in_ready     : operand handshake
//   in_sign/in_exp/in_mant: product sign, expA+expB-127, 48-bit product
//   out_valid/out_ready   : result handshake
//   out_result            : packed binary32
//   out_ovf/out_unf       : overflow to infinity / flush to zero
module fpmul_norm_ctrl
  import fpmul_pkg::*;
#(
  parameter int unsigned EXP_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic              out_ovf,
  output logic              out_unf
);

  state_t state, state_d;

  logic                  sign_q;
  logic signed [E_W-1:0] exp_q;
  logic [MANT_W-1:0]     mant_q;

  logic [LZ_W-1:0]       lz_c;
  logic                  zero_c;
  logic signed [E_W-1:0] e_norm_c;

  pack_res_t pack_c;
  logic      load_c;
  logic      in_ready_d;
  logic      out_valid_d;

  fpmul_lzc48 u_lzc (
    .mant (mant_q),
    .lz   (lz_c),
    .zero (zero_c)
  );

  // Product is value*2^-46, so a leading one at bit 47 means exponent +1.
  assign e_norm_c = exp_q + $signed(E_W'(1)) - $signed(E_W'(lz_c));

`ifdef FPMUL_RNE_EN
  localparam int unsigned G_BIT = MANT_W - 2 - FRAC_W;

  logic [MANT_W-2:0] m_q;  // normalized significand, hidden one dropped
  logic              zero_q;
  logic [FRAC_W-1:0] frac_c;
  logic [FRAC_W-1:0] frac_rnd_c;
  logic              inc_c;
  logic              carry_c;

  assign frac_c = m_q[MANT_W-2 -: FRAC_W];
  assign inc_c  = m_q[G_BIT] & ((|m_q[G_BIT-1:0]) | frac_c[0]);
  // Carry out of frac+inc equals the carry out of {1,frac}+inc.
  assign {carry_c, frac_rnd_c} = {1'b0, frac_c} + (FRAC_W + 1)'(inc_c);
`else
  logic [FRAC_W-1:0] frac_trunc_c;

  assign frac_trunc_c = FRAC_W'((mant_q << lz_c) >> (MANT_W - 1 - FRAC_W));
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:   if (in_valid) state_d = ST_NORM;
`ifdef FPMUL_RNE_EN
      ST_NORM:   state_d = ST_ROUND;
      ST_ROUND:  state_d = carry_c ? ST_RENORM : ST_OUT;
      ST_RENORM: state_d = ST_OUT;
`else
      ST_NORM:   state_d = ST_OUT;
`endif
      ST_OUT:    if (out_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic: handshake levels for the next cycle and the packed result
  // to load on entry to OUT.
  always_comb begin
    pack_c      = '0;
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_OUT);
    load_c      = (state_d == ST_OUT) && (state != ST_OUT);
    case (state)
`ifdef FPMUL_RNE_EN
      ST_ROUND:  pack_c = pack_fp32(sign_q, zero_q, exp_q, frac_rnd_c);
      ST_RENORM: pack_c = pack_fp32(sign_q, zero_q,
                                    exp_q + $signed(E_W'(1)), '0);
`else
      ST_NORM:   pack_c = pack_fp32(sign_q, zero_c, e_norm_c, frac_trunc_c);
`endif
      default:   pack_c = '0;
    endcase
  end

  // Operand capture and normalization datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q <= 1'b0;
      exp_q  <= '0;
      mant_q <= '0;
`ifdef FPMUL_RNE_EN
      m_q    <= '0;
      zero_q <= 1'b0;
`endif
    end else begin
      if (state == ST_IDLE && in_valid) begin
        sign_q <= in_sign;
        exp_q  <= E_W'($signed(in_exp));
        mant_q <= in_mant;
      end
      if (state == ST_NORM) begin
        exp_q  <= e_norm_c;
`ifdef FPMUL_RNE_EN
        m_q    <= (MANT_W - 1)'(mant_q << lz_c);
        zero_q <= zero_c;
`endif
      end
    end
  end

  // Registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_ovf    <= 1'b0;
      out_unf    <= 1'b0;
    end else begin
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      if (load_c) begin
        out_result <= pack_c.word;
        out_ovf    <= pack_c.ovf;
        out_unf    <= pack_c.unf;
      end
    end
  end

endmodule

// File: tb/tb_fpmul_norm_ctrl.sv
// Self-checking bench for fpmul_norm_ctrl: directed operand bundles with
// hand-computed results plus a value-level reference model checked every
// cycle the result is valid. Follows FPMUL_RNE_EN the same way as the design.
module tb_fpmul_norm_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exp = '0;
  logic [47:0] in_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_ovf;
  logic        out_unf;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_word = '0;
  logic        exp_ovf = 1'b0;
  logic        exp_unf = 1'b0;
  bit          chk_en = 1'b0;

  logic [31:0] prev_result = '0;
  logic        prev_valid = 1'b0;
  logic        prev_rst = 1'b1;

  fpmul_norm_ctrl #(.EXP_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ovf    (out_ovf),
    .out_unf    (out_unf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: locate the leading one, take 24 significant bits, round on the
  // discarded remainder, then range-check the biased exponent.
  function automatic void model(input logic s, input logic [9:0] e, input logic [47:0] m,
                                output logic [31:0] w, output logic ovf, output logic unf,
                                output int lat);
    int          p;
    longint      ex;
    logic [63:0] keep, rem, half;
    ovf = 1'b0;
    unf = 1'b0;
`ifdef FPMUL_RNE_EN
    lat = 3;
`else
    lat = 2;
`endif
    if (m == 48'd0) begin
      w = {s, 31'd0};
      return;
    end
    p = -1;
    for (int i = 0; i < 48; i++) if (m[i]) p = i;
    ex = longint'($signed(e)) + longint'(p) - 46;
    if (p >= 23) begin
      keep = {16'd0, m} >> (p - 23);
      rem  = {16'd0, m} & ((64'd1 << (p - 23)) - 64'd1);
    end else begin
      keep = {16'd0, m} << (23 - p);
      rem  = 64'd0;
    end
`ifdef FPMUL_RNE_EN
    if (p > 23) begin
      half = 64'd1 << (p - 24);
      if (rem > half || (rem == half && keep[0])) keep = keep + 64'd1;
      if (keep == (64'd1 << 24)) begin
        keep = keep >> 1;
        ex   = ex + 1;
        lat  = 4;
      end
    end
`else
    half = rem;
`endif
    if (ex >= 255) begin
      w   = {s, 8'hFF, 23'd0};
      ovf = 1'b1;
    end else if (ex <= 0) begin
      w   = {s, 31'd0};
      unf = 1'b1;
    end else begin
      w = {s, 8'(ex), keep[22:0]};
    end
  endfunction

  // Per-cycle compare against the model while a result is presented.
  always @(negedge clk) begin
    if (!rst && !prev_rst) begin
      if (out_valid && chk_en) begin
        chk("model_result", out_result, exp_word);
        chk("model_ovf", {31'd0, out_ovf}, {31'd0, exp_ovf});
        chk("model_unf", {31'd0, out_unf}, {31'd0, exp_unf});
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
      end
      if (!out_valid && !prev_valid)
        chk("result_hold", out_result, prev_result);
    end
    prev_rst    = rst;
    prev_valid  = out_valid;
    prev_result = out_result;
  end

  task automatic send(input logic s, input logic [9:0] e, input logic [47:0] m,
                      input int hold, input logic [31:0] lit,
                      input logic lovf, input logic lunf, input int llat);
    int k;
    int n;
    int lat;
    model(s, e, m, exp_word, exp_ovf, exp_unf, lat);
    chk_en = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_mant  = '0;
    k = 1;
    while (!out_valid && k < 12) begin
      @(negedge clk);
      k++;
    end
    chk("out_valid_seen", {31'd0, out_valid}, 32'd1);
    chk("latency", k, llat);
    chk("lit_result", out_result, lit);
    chk("lit_ovf", {31'd0, out_ovf}, {31'd0, lovf});
    chk("lit_unf", {31'd0, out_unf}, {31'd0, lunf});
    if (lat != llat) chk("model_latency", lat, llat);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk_en = 1'b0;
    chk("post_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("post_hs_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    chk("rst_out_unf", {31'd0, out_unf}, 32'd0);
    #2 rst = 1'b0;
    @(negedge clk);

`ifdef FPMUL_RNE_EN
    send(1'b0, 10'd127, 48'h9000_0000_0000, 0, 32'h4010_0000, 1'b0, 1'b0, 3);
    send(1'b0, 10'd127, 48'h4000_0000_0000, 1, 32'h3F80_0000, 1'b0, 1'b0, 3);
    send(1'b0, 10'd127, 48'hFFFF_FF80_0000, 0, 32'h4080_0000, 1'b0, 1'b0, 4);
    send(1'b0, 10'd127, 48'h8000_0180_0000, 0, 32'h4000_0002, 1'b0, 1'b0, 3);
    send(1'b0, 10'd127, 48'h8000_0080_0000, 0, 32'h4000_0000, 1'b0, 1'b0, 3);
    send(1'b0, 10'd254, 48'h8000_0000_0000, 0, 32'h7F80_0000, 1'b1, 1'b0, 3);
    send(1'b0, 10'd0,   48'h4000_0000_0000, 0, 32'h0000_0000, 1'b0, 1'b1, 3);
    send(1'b0, 10'h3FB, 48'h8000_0000_0000, 0, 32'h0000_0000, 1'b0, 1'b1, 3);
    send(1'b1, 10'd100, 48'h9000_0000_0000, 2, 32'hB290_0000, 1'b0, 1'b0, 3);
    send(1'b1, 10'd127, 48'h0000_0000_0000, 5, 32'h8000_0000, 1'b0, 1'b0, 3);
`else
    send(1'b0, 10'd127, 48'h9000_0000_0000, 0, 32'h4010_0000, 1'b0, 1'b0, 2);
    send(1'b0, 10'd127, 48'h4000_0000_0000, 1, 32'h3F80_0000, 1'b0, 1'b0, 2);
    send(1'b0, 10'd127, 48'hFFFF_FF80_0000, 0, 32'h407F_FFFF, 1'b0, 1'b0, 2);
    send(1'b0, 10'd127, 48'h8000_0180_0000, 0, 32'h4000_0001, 1'b0, 1'b0, 2);
    send(1'b0, 10'd127, 48'h8000_0080_0000, 0, 32'h4000_0000, 1'b0, 1'b0, 2);
    send(1'b0, 10'd254, 48'h8000_0000_0000, 0, 32'h7F80_0000, 1'b1, 1'b0, 2);
    send(1'b0, 10'd0,   48'h4000_0000_0000, 0, 32'h0000_0000, 1'b0, 1'b1, 2);
    send(1'b0, 10'h3FB, 48'h8000_0000_0000, 0, 32'h0000_0000, 1'b0, 1'b1, 2);
    send(1'b1, 10'd100, 48'h9000_0000_0000, 2, 32'hB290_0000, 1'b0, 1'b0, 2);
    send(1'b1, 10'd127, 48'h0000_0000_0000, 5, 32'h8000_0000, 1'b0, 1'b0, 2);
`endif

    // Abort an operation with reset two cycles after accept.
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = 1'b0;
    in_exp   = 10'd127;
    in_mant  = 48'h9000_0000_0000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_result", out_result, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("postrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("postrst_out_valid", {31'd0, out_valid}, 32'd0);

`ifdef FPMUL_RNE_EN
    send(1'b0, 10'd127, 48'h4000_0000_0000, 0, 32'h3F80_0000, 1'b0, 1'b0, 3);
`else
    send(1'b0, 10'd127, 48'h4000_0000_0000, 0, 32'h3F80_0000, 1'b0, 1'b0, 2);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
